param_control_unit: RTL and testbench
=====================================

Name: param_control_unit

Overview:
- Next-generation multicycle control unit for the six-instruction processor family.
- Fetches from an external instruction memory, decodes, and drives the existing Datapath control bus: D_addr, D_wr, RF_s, RF_W_addr/en, RF_Ra/Rb_addr, Alu_s0.
- Adds three things the prior unit lacks: parametrised PC width and start address, JMP/JMPZ control flow, and a single-step debug mode with an illegal-opcode flag.

Parameters:
- PC_W, 8, program-counter and instruction-address width (4..8); jump targets use IR[PC_W-1:0].
- START_PC, 0, PC value loaded on Reset.
- STEP_MODE, 0, 1 enables the single-step gate in FETCH.

Ports:
- Clk  in  1  processor clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- im_addr  out  PC_W  instruction address; equals PC_Out.
- im_rdata  in  16  instruction word; must be valid in the same cycle as im_addr (asynchronous read).
- rf_zero  in  1  datapath flag: RF[RF_Ra_addr]==0.
- Step  in  1  single-step pulse; used only when STEP_MODE=1.
- D_addr  out  8  data-memory address.
- D_wr  out  1  data-memory write strobe.
- RF_s  out  1  register-file write mux select: 1=memory, 0=ALU.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  4  register-file A read address.
- RF_Rb_addr  out  4  register-file B read address.
- Alu_s0  out  3  ALU select: 000 pass, 001 add, 010 sub.
- IR_Out  out  16  instruction register.
- PC_Out  out  PC_W  program counter.
- StateOut  out  4  current state encoding.
- NextState  out  4  combinational next state.
- illegal  out  1  one-cycle pulse in DECODE when the opcode is 1000..1111.
- halted  out  1  high while in HALT.

Behaviour:
- Opcodes (IR[15:12]):
  - 0 NOOP.
  - 1 STORE: mem[IR[7:0]] <= RF[IR[11:8]].
  - 2 LOAD: RF[IR[3:0]] <= mem[IR[11:4]].
  - 3 ADD: RF[IR[3:0]] <= RF[IR[11:8]] + RF[IR[7:4]].
  - 4 SUB: same fields, subtraction.
  - 5 HALT.
  - 6 JMP: PC <= IR[PC_W-1:0].
  - 7 JMPZ: if RF[IR[11:8]]==0, PC <= IR[PC_W-1:0].
  - 8..15: treated as NOOP, with illegal pulsed.
- State encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9, JUMP=10, JMPZ=11.
- Reset=1: next edge gives state=INIT, PC=START_PC, IR=0. While Reset=1, D_wr and RF_W_en are combinationally forced 0, so no write can occur in the reset cycle, even mid-STORE or mid-LOAD_B.
- INIT -> FETCH unconditionally (1 cycle).
- FETCH exit edge: IR <= im_rdata, PC <= PC+1 (mod 2^PC_W), then -> DECODE.
  - With STEP_MODE=1, FETCH holds (no IR or PC update) until Step=1 is sampled in FETCH.
  - Step is ignored in every other state; a Step held high advances one instruction per pass through FETCH.
- DECODE -> execute state by opcode. HALT opcode -> HALT. Illegal opcode -> NOOP.
- Execute states all return to FETCH, except LOAD_A -> LOAD_B -> FETCH.
- Per-state outputs; anything not listed is 0:
  - STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], D_wr=1.
  - LOAD_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0].
  - LOAD_B: as LOAD_A, plus RF_W_en=1.
  - ADD/SUB: Ra=IR[11:8], Rb=IR[7:4], W=IR[3:0], RF_W_en=1, Alu_s0=001 (ADD) or 010 (SUB).
  - JMPZ: RF_Ra_addr=IR[11:8]. rf_zero is sampled in JMPZ; taken -> PC <= target at exit edge, not taken -> PC unchanged.
  - JUMP: PC <= target at exit edge.
- Latency in cycles, FETCH through last execute: NOOP/STORE/ADD/SUB/JMP/JMPZ = 3, LOAD = 4.
- HALT is sticky until Reset; outputs stay idle and halted=1.
- PC wrap: after a fetch at 2^PC_W-1, PC becomes 0.
- A jump to its own address loops indefinitely; this is legal.
- Target bits IR[7:PC_W] are ignored.

Decomposition:
- Package proc_pkg holds:
  - the state_t enum (4-bit, encodings above);
  - opcode localparams OP_NOOP..OP_JMPZ;
  - ALU select constants ALU_PASS/ALU_ADD/ALU_SUB.
- No separate sub-module. Implement as a single FSM with registered state, PC and IR, plus combinational next-state and output decode.

Test Plan:
- Reset: assert Reset 2 cycles mid-STORE -> D_wr=0 during reset, then StateOut 0, 1, 2; PC_Out=START_PC; IR_Out=0.
- Program:
  - 0x2A01: LOAD R1<=mem[0xA0] -> RF_W_en high only in LOAD_B, D_addr=0xA0, RF_s=1.
  - 0x3124: ADD R4=R1+R2 -> Alu_s0=001, RF_W_en=1 for one cycle.
  - 0x1405: STORE mem[0x05]<=R4 -> D_wr=1, D_addr=0x05.
- JMPZ 0x7310:
  - rf_zero=1 -> PC_Out=0x10 at next FETCH.
  - rf_zero=0 -> PC_Out=old PC+1.
- JMP 0x60FF with PC_W=4 -> PC_Out=0xF. A subsequent fetch at 0xF wraps PC to 0.
- Opcode 0xB000 -> illegal pulses for 1 cycle, NOOP path taken, no writes. HALT 0x5000 -> halted=1, StateOut=9 held for 20 cycles.
- STEP_MODE=1: no Step for 10 cycles -> StateOut stays 1. A one-cycle Step pulse -> exactly one instruction executes, then FETCH holds again.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the six-instruction processor control unit:
// state encodings, opcode values and ALU select codes.
package proc_pkg;

   // Controller states; encodings are visible on StateOut/NextState
   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9,
      S_JUMP   = 4'd10,
      S_JMPZ   = 4'd11
   } state_t;

   // Opcodes carried in IR[15:12]; 8..15 are illegal and execute as NOOP
   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;
   localparam logic [3:0] OP_JMP   = 4'd6;
   localparam logic [3:0] OP_JMPZ  = 4'd7;

   // Datapath ALU select codes
   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/param_control_unit.sv
// Multicycle control unit: fetches from an asynchronous instruction memory,
// decodes, and drives the datapath control bus. Supports JMP/JMPZ, a
// parametrised PC, and an optional single-step gate in FETCH.
module param_control_unit
   import proc_pkg::*;
#(
   parameter int         PC_W      = 8,
   parameter logic [7:0] START_PC  = 8'd0,
   parameter bit         STEP_MODE = 1'b0
) (
   input  logic            Clk,
   input  logic            Reset,
   output logic [PC_W-1:0] im_addr,
   input  logic [15:0]     im_rdata,
   input  logic            rf_zero,
   input  logic            Step,
   output logic [7:0]      D_addr,
   output logic            D_wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_addr,
   output logic            RF_W_en,
   output logic [3:0]      RF_Ra_addr,
   output logic [3:0]      RF_Rb_addr,
   output logic [2:0]      Alu_s0,
   output logic [15:0]     IR_Out,
   output logic [PC_W-1:0] PC_Out,
   output logic [3:0]      StateOut,
   output logic [3:0]      NextState,
   output logic            illegal,
   output logic            halted
);

   localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [PC_W-1:0] PC_RESET = START_PC[PC_W-1:0];

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [PC_W-1:0] jump_target;
   logic            fetch_go;
   logic            d_wr_raw;
   logic            rf_w_en_raw;

   // Jump target bits above PC_W are simply dropped
   assign jump_target = ir_q[PC_W-1:0];
   // Without the step gate, FETCH always completes in one cycle
   assign fetch_go    = (STEP_MODE == 1'b0) || Step;

   // Next-state, PC and IR update logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH: begin
            if (fetch_go) begin
               ir_d    = im_rdata;
               pc_d    = pc_q + PC_ONE;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (ir_q[15:12])
               OP_NOOP:  state_d = S_NOOP;
               OP_STORE: state_d = S_STORE;
               OP_LOAD:  state_d = S_LOAD_A;
               OP_ADD:   state_d = S_ADD;
               OP_SUB:   state_d = S_SUB;
               OP_HALT:  state_d = S_HALT;
               OP_JMP:   state_d = S_JUMP;
               OP_JMPZ:  state_d = S_JMPZ;
               default:  state_d = S_NOOP;
            endcase
         end
         S_LOAD_A: state_d = S_LOAD_B;
         S_JUMP: begin
            pc_d    = jump_target;
            state_d = S_FETCH;
         end
         S_JMPZ: begin
            if (rf_zero) begin
               pc_d = jump_target;
            end
            state_d = S_FETCH;
         end
         S_HALT:   state_d = S_HALT;
         S_NOOP,
         S_LOAD_B,
         S_STORE,
         S_ADD,
         S_SUB:    state_d = S_FETCH;
         default:  state_d = S_INIT;
      endcase
   end

   // Per-state datapath control decode; unlisted controls stay 0
   always_comb begin
      D_addr      = 8'h00;
      d_wr_raw    = 1'b0;
      RF_s        = 1'b0;
      RF_W_addr   = 4'h0;
      rf_w_en_raw = 1'b0;
      RF_Ra_addr  = 4'h0;
      RF_Rb_addr  = 4'h0;
      Alu_s0      = ALU_PASS;
      case (state_q)
         S_STORE: begin
            D_addr     = ir_q[7:0];
            RF_Ra_addr = ir_q[11:8];
            d_wr_raw   = 1'b1;
         end
         S_LOAD_A: begin
            D_addr    = ir_q[11:4];
            RF_s      = 1'b1;
            RF_W_addr = ir_q[3:0];
         end
         S_LOAD_B: begin
            D_addr      = ir_q[11:4];
            RF_s        = 1'b1;
            RF_W_addr   = ir_q[3:0];
            rf_w_en_raw = 1'b1;
         end
         S_ADD: begin
            RF_Ra_addr  = ir_q[11:8];
            RF_Rb_addr  = ir_q[7:4];
            RF_W_addr   = ir_q[3:0];
            rf_w_en_raw = 1'b1;
            Alu_s0      = ALU_ADD;
         end
         S_SUB: begin
            RF_Ra_addr  = ir_q[11:8];
            RF_Rb_addr  = ir_q[7:4];
            RF_W_addr   = ir_q[3:0];
            rf_w_en_raw = 1'b1;
            Alu_s0      = ALU_SUB;
         end
         S_JMPZ: begin
            RF_Ra_addr = ir_q[11:8];
         end
         default: begin
            D_addr = 8'h00;
         end
      endcase
   end

   // Write strobes are gated by Reset so a reset landing mid-STORE or
   // mid-LOAD_B can never commit a write
   assign D_wr      = d_wr_raw && !Reset;
   assign RF_W_en   = rf_w_en_raw && !Reset;

   assign illegal   = (state_q == S_DECODE) && ir_q[15];
   assign halted    = (state_q == S_HALT);
   assign im_addr   = pc_q;
   assign PC_Out    = pc_q;
   assign IR_Out    = ir_q;
   assign StateOut  = state_q;
   assign NextState = state_d;

   // State, PC and IR registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_INIT;
         pc_q    <= PC_RESET;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

endmodule

// File: tb/tb_param_control_unit.sv
// Directed bench for param_control_unit: a vector table run through the
// default configuration, plus hand sequences for reset-mid-STORE, HALT,
// PC_W=4 wrap with non-zero START_PC, and single-step mode.
module tb_param_control_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance A: PC_W=8, START_PC=0, no step ----------
   logic        a_rst, a_zf, a_step;
   logic [15:0] a_rdata;
   logic [7:0]  a_imaddr, a_pc, a_daddr;
   logic        a_dwr, a_rfs, a_wen, a_ill, a_halt;
   logic [3:0]  a_wa, a_ra, a_rb, a_state, a_next;
   logic [2:0]  a_alu;
   logic [15:0] a_ir;

   param_control_unit #(.PC_W(8), .START_PC(8'h00), .STEP_MODE(1'b0)) dut_a (
      .Clk(clk), .Reset(a_rst), .im_addr(a_imaddr), .im_rdata(a_rdata),
      .rf_zero(a_zf), .Step(a_step), .D_addr(a_daddr), .D_wr(a_dwr),
      .RF_s(a_rfs), .RF_W_addr(a_wa), .RF_W_en(a_wen), .RF_Ra_addr(a_ra),
      .RF_Rb_addr(a_rb), .Alu_s0(a_alu), .IR_Out(a_ir), .PC_Out(a_pc),
      .StateOut(a_state), .NextState(a_next), .illegal(a_ill), .halted(a_halt));

   // ---------------- instance B: PC_W=4, START_PC=5 -------------------
   logic        b_rst, b_zf, b_step;
   logic [15:0] b_rdata;
   logic [3:0]  b_imaddr, b_pc;
   logic [7:0]  b_daddr;
   logic        b_dwr, b_rfs, b_wen, b_ill, b_halt;
   logic [3:0]  b_wa, b_ra, b_rb, b_state, b_next;
   logic [2:0]  b_alu;
   logic [15:0] b_ir;

   param_control_unit #(.PC_W(4), .START_PC(8'h05), .STEP_MODE(1'b0)) dut_b (
      .Clk(clk), .Reset(b_rst), .im_addr(b_imaddr), .im_rdata(b_rdata),
      .rf_zero(b_zf), .Step(b_step), .D_addr(b_daddr), .D_wr(b_dwr),
      .RF_s(b_rfs), .RF_W_addr(b_wa), .RF_W_en(b_wen), .RF_Ra_addr(b_ra),
      .RF_Rb_addr(b_rb), .Alu_s0(b_alu), .IR_Out(b_ir), .PC_Out(b_pc),
      .StateOut(b_state), .NextState(b_next), .illegal(b_ill), .halted(b_halt));

   // ---------------- instance C: PC_W=8, START_PC=0x20, step mode -----
   logic        c_rst, c_zf, c_step;
   logic [15:0] c_rdata;
   logic [7:0]  c_imaddr, c_pc, c_daddr;
   logic        c_dwr, c_rfs, c_wen, c_ill, c_halt;
   logic [3:0]  c_wa, c_ra, c_rb, c_state, c_next;
   logic [2:0]  c_alu;
   logic [15:0] c_ir;

   param_control_unit #(.PC_W(8), .START_PC(8'h20), .STEP_MODE(1'b1)) dut_c (
      .Clk(clk), .Reset(c_rst), .im_addr(c_imaddr), .im_rdata(c_rdata),
      .rf_zero(c_zf), .Step(c_step), .D_addr(c_daddr), .D_wr(c_dwr),
      .RF_s(c_rfs), .RF_W_addr(c_wa), .RF_W_en(c_wen), .RF_Ra_addr(c_ra),
      .RF_Rb_addr(c_rb), .Alu_s0(c_alu), .IR_Out(c_ir), .PC_Out(c_pc),
      .StateOut(c_state), .NextState(c_next), .illegal(c_ill), .halted(c_halt));

   typedef struct packed {
      logic [15:0] instr;
      logic        zf;
      logic [3:0]  st;
      logic [7:0]  daddr;
      logic        dwr;
      logic        rfs;
      logic [3:0]  wa;
      logic        wen;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  alu;
      logic        ill;
      logic        jmp;
   } vec_t;

   vec_t       vecs [10];
   logic [7:0] exp_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fetch_a();
      int n = 0;
      while (a_state != 4'd1 && n < 12) begin
         tick();
         n++;
      end
      chk("a_fetch_reached", 32'(a_state), 32'd1);
   endtask

   initial begin
      //            instr     zf    st     daddr  dwr   rfs   wa     wen   ra     rb     alu   ill   jmp
      vecs[0] = '{16'h2A01, 1'b0, 4'd4,  8'hA0, 1'b0, 1'b1, 4'd1,  1'b0, 4'd0,  4'd0,  3'd0, 1'b0, 1'b0};
      vecs[1] = '{16'h3124, 1'b0, 4'd7,  8'h00, 1'b0, 1'b0, 4'd4,  1'b1, 4'd1,  4'd2,  3'd1, 1'b0, 1'b0};
      vecs[2] = '{16'h4567, 1'b0, 4'd8,  8'h00, 1'b0, 1'b0, 4'd7,  1'b1, 4'd5,  4'd6,  3'd2, 1'b0, 1'b0};
      vecs[3] = '{16'h1405, 1'b0, 4'd6,  8'h05, 1'b1, 1'b0, 4'd0,  1'b0, 4'd4,  4'd0,  3'd0, 1'b0, 1'b0};
      vecs[4] = '{16'h0123, 1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  4'd0,  3'd0, 1'b0, 1'b0};
      vecs[5] = '{16'h7310, 1'b1, 4'd11, 8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 4'd3,  4'd0,  3'd0, 1'b0, 1'b1};
      vecs[6] = '{16'h7310, 1'b0, 4'd11, 8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 4'd3,  4'd0,  3'd0, 1'b0, 1'b0};
      vecs[7] = '{16'hB000, 1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  4'd0,  3'd0, 1'b1, 1'b0};
      vecs[8] = '{16'h6042, 1'b0, 4'd10, 8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  4'd0,  3'd0, 1'b0, 1'b1};
      vecs[9] = '{16'hF0FF, 1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  4'd0,  3'd0, 1'b1, 1'b0};

      a_rst = 1'b1; a_zf = 1'b0; a_step = 1'b0; a_rdata = 16'h0000;
      b_rst = 1'b1; b_zf = 1'b0; b_step = 1'b0; b_rdata = 16'h0000;
      c_rst = 1'b1; c_zf = 1'b0; c_step = 1'b0; c_rdata = 16'h0000;
      tick();
      tick();
      chk("a_reset_state", 32'(a_state), 32'd0);
      a_rst = 1'b0;

      // ---- reset landing mid-STORE ----
      wait_fetch_a();
      a_rdata = 16'h1405;
      tick();
      tick();
      chk("a_store_state", 32'(a_state), 32'd6);
      chk("a_store_dwr", 32'(a_dwr), 32'd1);
      a_rst = 1'b1;
      a_rdata = 16'h0000;
      #1;
      chk("a_rst_dwr_forced", 32'(a_dwr), 32'd0);
      chk("a_rst_wen_forced", 32'(a_wen), 32'd0);
      tick();
      chk("a_rst1_state", 32'(a_state), 32'd0);
      chk("a_rst1_pc", 32'(a_pc), 32'h00);
      chk("a_rst1_ir", 32'(a_ir), 32'h0000);
      chk("a_rst1_dwr", 32'(a_dwr), 32'd0);
      tick();
      chk("a_rst2_state", 32'(a_state), 32'd0);
      a_rst = 1'b0;
      tick();
      chk("a_post_rst_fetch", 32'(a_state), 32'd1);
      chk("a_post_rst_imaddr", 32'(a_imaddr), 32'h00);
      tick();
      chk("a_post_rst_decode", 32'(a_state), 32'd2);
      chk("a_post_rst_pc", 32'(a_pc), 32'h01);
      exp_pc = 8'h01;

      // ---- table-driven instruction vectors ----
      for (int i = 0; i < 10; i++) begin
         wait_fetch_a();
         chk($sformatf("v%0d_fetch_pc", i), 32'(a_pc), 32'(exp_pc));
         a_rdata = vecs[i].instr;
         a_zf    = vecs[i].zf;
         tick();
         exp_pc = exp_pc + 8'd1;
         chk($sformatf("v%0d_decode", i), 32'(a_state), 32'd2);
         chk($sformatf("v%0d_ir", i), 32'(a_ir), 32'(vecs[i].instr));
         chk($sformatf("v%0d_illegal_dec", i), 32'(a_ill), 32'(vecs[i].ill));
         chk($sformatf("v%0d_next", i), 32'(a_next), 32'(vecs[i].st));
         tick();
         chk($sformatf("v%0d_exec_state", i), 32'(a_state), 32'(vecs[i].st));
         chk($sformatf("v%0d_daddr", i), 32'(a_daddr), 32'(vecs[i].daddr));
         chk($sformatf("v%0d_dwr", i), 32'(a_dwr), 32'(vecs[i].dwr));
         chk($sformatf("v%0d_rfs", i), 32'(a_rfs), 32'(vecs[i].rfs));
         chk($sformatf("v%0d_waddr", i), 32'(a_wa), 32'(vecs[i].wa));
         chk($sformatf("v%0d_wen", i), 32'(a_wen), 32'(vecs[i].wen));
         chk($sformatf("v%0d_ra", i), 32'(a_ra), 32'(vecs[i].ra));
         chk($sformatf("v%0d_rb", i), 32'(a_rb), 32'(vecs[i].rb));
         chk($sformatf("v%0d_alu", i), 32'(a_alu), 32'(vecs[i].alu));
         chk($sformatf("v%0d_illegal_exec", i), 32'(a_ill), 32'd0);
         if (vecs[i].st == 4'd4) begin
            tick();
            chk($sformatf("v%0d_loadb_state", i), 32'(a_state), 32'd5);
            chk($sformatf("v%0d_loadb_wen", i), 32'(a_wen), 32'd1);
            chk($sformatf("v%0d_loadb_daddr", i), 32'(a_daddr), 32'(vecs[i].daddr));
            chk($sformatf("v%0d_loadb_rfs", i), 32'(a_rfs), 32'd1);
            chk($sformatf("v%0d_loadb_waddr", i), 32'(a_wa), 32'(vecs[i].wa));
         end
         if (vecs[i].jmp) exp_pc = vecs[i].instr[7:0];
         tick();
         chk($sformatf("v%0d_back_fetch", i), 32'(a_state), 32'd1);
         chk($sformatf("v%0d_next_pc", i), 32'(a_pc), 32'(exp_pc));
      end

      // ---- HALT is sticky ----
      wait_fetch_a();
      a_rdata = 16'h5000;
      tick();
      tick();
      for (int k = 0; k < 20; k++) begin
         chk("a_halt_state", 32'(a_state), 32'd9);
         chk("a_halted", 32'(a_halt), 32'd1);
         chk("a_halt_writes", 32'({a_dwr, a_wen}), 32'd0);
         tick();
      end

      // ---- PC_W=4: START_PC, JMP target truncation, PC wrap ----
      b_rst = 1'b1;
      tick();
      chk("b_reset_pc", 32'(b_pc), 32'h5);
      chk("b_reset_state", 32'(b_state), 32'd0);
      b_rst = 1'b0;
      tick();
      chk("b_fetch_state", 32'(b_state), 32'd1);
      chk("b_fetch_imaddr", 32'(b_imaddr), 32'h5);
      b_rdata = 16'h60FF;
      tick();
      chk("b_decode_pc", 32'(b_pc), 32'h6);
      tick();
      chk("b_jump_state", 32'(b_state), 32'd10);
      b_rdata = 16'h0000;
      tick();
      chk("b_jump_fetch", 32'(b_state), 32'd1);
      chk("b_jump_pc", 32'(b_pc), 32'hF);
      chk("b_jump_imaddr", 32'(b_imaddr), 32'hF);
      tick();
      chk("b_wrap_decode", 32'(b_state), 32'd2);
      chk("b_wrap_pc", 32'(b_pc), 32'h0);

      // ---- single-step mode ----
      c_rst = 1'b1;
      tick();
      c_rst = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("c_hold_state", 32'(c_state), 32'd1);
         chk("c_hold_pc", 32'(c_pc), 32'h20);
      end
      c_rdata = 16'h3124;
      c_step  = 1'b1;
      tick();
      c_step  = 1'b0;
      c_rdata = 16'h0000;
      chk("c_step_decode", 32'(c_state), 32'd2);
      chk("c_step_pc", 32'(c_pc), 32'h21);
      chk("c_step_ir", 32'(c_ir), 32'h3124);
      tick();
      chk("c_step_add", 32'(c_state), 32'd7);
      chk("c_step_add_wen", 32'(c_wen), 32'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("c_rehold_state", 32'(c_state), 32'd1);
         chk("c_rehold_pc", 32'(c_pc), 32'h21);
      end
      c_step = 1'b1;
      tick();
      chk("c_held_pc1", 32'(c_pc), 32'h22);
      tick();
      tick();
      tick();
      chk("c_held_state2", 32'(c_state), 32'd2);
      chk("c_held_pc2", 32'(c_pc), 32'h23);
      c_step = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
